// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states and
// request-classification helpers.
package lsu_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    // Access size lives in Op[1:0], zero-extension in Op[2].
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} lsu_state_e;

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lane);
        case (op[1:0])
            SZ_H:    return lane[0];
            SZ_W:    return lane != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts/extends a load value from a memory word and
// merges a sub-word store operand into it.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_val_o,
    output logic [31:0] st_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = word_i[{lane_i, 3'b000} +: 8];
        half_sel  = word_i[{lane_i[1], 4'b0000} +: 16];
        ld_val_o  = word_i;
        st_word_o = st_data_i;
        case (size_i)
            SZ_B: begin
                ld_val_o  = unsigned_i ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                st_word_o = word_i;
                st_word_o[{lane_i, 3'b000} +: 8] = st_data_i[7:0];
            end
            SZ_H: begin
                ld_val_o  = unsigned_i ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                st_word_o = word_i;
                st_word_o[{lane_i[1], 4'b0000} +: 16] = st_data_i[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequences one load/store at a time against a word-wide combinational-read
// memory; sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Req,
    input  logic [3:0]        Op,
    input  logic [31:0]       Addr,
    input  logic [31:0]       Store_Data,
    output logic              Busy,
    output logic              Done,
    output logic [31:0]       Load_Data,
    output logic              Error,
    output logic [ADDR_W-1:0] Memory_Address,
    output logic [31:0]       Memory_Write_Data,
    output logic              Memory_allow_Write,
    input  logic [31:0]       Memory_Output_Data
);

    lsu_state_e        state_q, state_d;
    logic [3:0]        op_q;
    logic [1:0]        lane_q;
    logic [31:0]       st_q;
    logic              err_q;
    logic [31:0]       load_q, wdata_q;
    logic [ADDR_W-1:0] maddr_q;
    logic              req_err;
    logic [31:0]       ld_ext, st_merge;
    logic              unused_addr;

    assign req_err     = !is_legal(Op) || misaligned(Op, Addr[1:0]);
    assign unused_addr = ^Addr[31:ADDR_W+2];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Req) begin
                    if (req_err)          state_d = DONE;
                    else if (Op == OP_SW) state_d = WRITE;
                    else                  state_d = READ;
                end
            end
            READ:    state_d = is_store(op_q) ? WRITE : DONE;
            WRITE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Request is captured on accept; the memory word is consumed straight off
    // the read port in READ, either as load data or as the RMW merge base.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            op_q    <= '0;
            lane_q  <= '0;
            st_q    <= '0;
            err_q   <= 1'b0;
            load_q  <= '0;
            wdata_q <= '0;
            maddr_q <= '0;
        end else begin
            if (state_q == IDLE && Req) begin
                op_q    <= Op;
                lane_q  <= Addr[1:0];
                st_q    <= Store_Data;
                err_q   <= req_err;
                maddr_q <= Addr[ADDR_W+1:2];
                if (Op == OP_SW && !req_err) wdata_q <= Store_Data;
            end
            if (state_q == READ) begin
                if (is_store(op_q)) wdata_q <= st_merge;
                else                load_q  <= ld_ext;
            end
        end
    end

    lsu_align u_align (
        .word_i     (Memory_Output_Data),
        .lane_i     (lane_q),
        .size_i     (op_q[1:0]),
        .unsigned_i (op_q[2]),
        .st_data_i  (st_q),
        .ld_val_o   (ld_ext),
        .st_word_o  (st_merge)
    );

    // Write enable decodes straight from state so an async reset kills it at once.
    assign Busy               = (state_q != IDLE);
    assign Done               = (state_q == DONE);
    assign Error              = (state_q == DONE) && err_q;
    assign Memory_allow_Write = (state_q == WRITE);
    assign Load_Data          = load_q;
    assign Memory_Address     = maddr_q;
    assign Memory_Write_Data  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed cases plus random ops against a byte-array
// reference memory.
module tb_load_store_unit;

    localparam int ADDR_W = 16;
    localparam logic [3:0] OP_LB = 4'b0000, OP_LH = 4'b0001, OP_LW = 4'b0010,
                           OP_LBU = 4'b0100, OP_LHU = 4'b0101,
                           OP_SB = 4'b1000, OP_SH = 4'b1001, OP_SW = 4'b1010;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              Req;
    logic [3:0]        Op;
    logic [31:0]       Addr, Store_Data;
    logic              Busy, Done, Error, Memory_allow_Write;
    logic [31:0]       Load_Data, Memory_Write_Data, Memory_Output_Data;
    logic [ADDR_W-1:0] Memory_Address;

    logic [31:0] mem    [64];
    logic [31:0] init_w [64];
    logic        init_en = 1'b0;
    logic [7:0]  ref_mem [256];
    logic [31:0] exp_ld;
    int          n_chk = 0, n_fail = 0;

    always #5 Clk = ~Clk;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Op(Op), .Addr(Addr),
        .Store_Data(Store_Data), .Busy(Busy), .Done(Done), .Load_Data(Load_Data),
        .Error(Error), .Memory_Address(Memory_Address),
        .Memory_Write_Data(Memory_Write_Data), .Memory_allow_Write(Memory_allow_Write),
        .Memory_Output_Data(Memory_Output_Data)
    );

    assign Memory_Output_Data = mem[Memory_Address[5:0]];

    always @(posedge Clk) begin
        if (init_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_w[i];
        end else if (Memory_allow_Write) begin
            mem[Memory_Address[5:0]] <= Memory_Write_Data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int base);
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd);
        logic        legal, err, st;
        int          sz, a, lat, wcnt, wcyc, exp_lat, exp_wcyc;
        logic [31:0] v, exp_w, wdata;
        legal = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        sz    = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        a     = int'(addr[7:0]);
        err   = !legal || (a % sz != 0);
        st    = op[3];
        exp_w = '0;
        if (!err && !st) begin
            v = '0;
            for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[a+k]) << (8*k));
            if (!op[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
            exp_ld = v;
        end
        if (!err && st) begin
            for (int k = 0; k < sz; k++) ref_mem[a+k] = sd[8*k +: 8];
            exp_w = ref_word(a & ~3);
        end
        exp_lat  = err ? 1 : (st ? ((sz == 4) ? 2 : 3) : 2);
        exp_wcyc = (sz == 4) ? 1 : 2;

        @(negedge Clk);
        Req = 1'b1; Op = op; Addr = addr; Store_Data = sd;
        @(posedge Clk); #1;
        Req = 1'b0; Op = 4'($urandom); Addr = $urandom; Store_Data = $urandom;
        lat = 1; wcnt = 0; wcyc = 0; wdata = '0;
        forever begin
            if (Memory_allow_Write) begin wcnt++; wcyc = lat; wdata = Memory_Write_Data; end
            if (Done || lat >= 8) break;
            @(posedge Clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("done", Done, 1'b1);
        chk("error", Error, err);
        chk("load_data", Load_Data, exp_ld);
        chk("write_count", wcnt, (!err && st) ? 1 : 0);
        if (!err && st) begin
            chk("write_cycle", wcyc, exp_wcyc);
            chk("write_data", wdata, exp_w);
        end
        if (!err) chk("mem_addr", Memory_Address, addr[ADDR_W+1:2]);
        @(posedge Clk); #1;
        chk("done_pulse", Done, 1'b0);
        chk("idle_after", Busy, 1'b0);
    endtask

    initial begin
        int nd, gap;
        logic prev_done;
        logic [3:0] legal_ops [8];
        logic [3:0] rop;
        legal_ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

        Reset_n = 1'b0; Req = 1'b0; Op = '0; Addr = '0; Store_Data = '0;
        for (int i = 0; i < 64; i++) init_w[i] = $urandom;
        init_w[4] = 32'h8899AABC;
        for (int i = 0; i < 64; i++)
            for (int k = 0; k < 4; k++) ref_mem[4*i+k] = init_w[i][8*k +: 8];
        exp_ld = '0;

        #2;
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_error", Error, 1'b0);
        chk("rst_ld", Load_Data, 32'h0);
        chk("rst_maddr", Memory_Address, '0);
        chk("rst_wdata", Memory_Write_Data, 32'h0);
        chk("rst_we", Memory_allow_Write, 1'b0);

        init_en = 1'b1;
        @(posedge Clk); #1;
        init_en = 1'b0;
        @(negedge Clk); Reset_n = 1'b1;

        do_op(OP_LB,  32'h11, 32'h0);
        chk("lb_val", Load_Data, 32'hFFFFFFAA);
        do_op(OP_LHU, 32'h12, 32'h0);
        chk("lhu_val", Load_Data, 32'h00008899);
        do_op(OP_LH,  32'h12, 32'h0);
        chk("lh_val", Load_Data, 32'hFFFF8899);
        do_op(OP_LW,  32'h10, 32'h0);
        chk("lw_val", Load_Data, 32'h8899AABC);
        do_op(OP_SB,  32'h13, 32'h000000EE);
        do_op(OP_LW,  32'h10, 32'h0);
        chk("sb_then_lw", Load_Data, 32'hEE99AABC);
        do_op(OP_SH,  32'h11, 32'h12345678);
        do_op(OP_LW,  32'h12, 32'h0);
        do_op(4'b0011, 32'h10, 32'h0);
        chk("err_keeps_ld", Load_Data, 32'hEE99AABC);

        // Req held high: every accept must be preceded by an IDLE cycle.
        @(negedge Clk);
        Req = 1'b1; Op = OP_LW; Addr = 32'h10;
        nd = 0; gap = 0; prev_done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge Clk); #1;
            if (prev_done && Busy) gap++;
            if (Done) nd++;
            if (Memory_allow_Write) gap++;
            prev_done = Done;
        end
        Req = 1'b0;
        exp_ld = ref_word(32'h10);
        chk("hold_done_cnt", nd, 3);
        chk("hold_gap", gap, 0);
        chk("hold_ld", Load_Data, exp_ld);

        for (int n = 0; n < 150; n++) begin
            rop = ($urandom_range(9) == 0) ? 4'($urandom) : legal_ops[$urandom_range(7)];
            do_op(rop, {14'($urandom), 10'b0, 8'($urandom)}, $urandom);
        end

        // Reset during the WRITE cycle of an SH must abort without touching memory.
        @(negedge Clk);
        Req = 1'b1; Op = OP_SH; Addr = 32'h22; Store_Data = 32'h12345678;
        @(posedge Clk); #1; Req = 1'b0;
        @(posedge Clk); #1;
        chk("rst_mid_we_pre", Memory_allow_Write, 1'b1);
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_mid_we", Memory_allow_Write, 1'b0);
        chk("rst_mid_busy", Busy, 1'b0);
        chk("rst_mid_done", Done, 1'b0);
        chk("rst_mid_error", Error, 1'b0);
        chk("rst_mid_ld", Load_Data, 32'h0);
        chk("rst_mid_maddr", Memory_Address, '0);
        chk("rst_mid_wdata", Memory_Write_Data, 32'h0);
        @(negedge Clk); @(negedge Clk);
        Reset_n = 1'b1;
        exp_ld = '0;
        do_op(OP_LW, 32'h20, 32'h0);

        for (int i = 0; i < 64; i++) chk("mem_final", mem[i], ref_word(4*i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
